// File: rtl/bench.sv
// Instruction-fetch and control-flow core: sequences JP, CALL, CALZ, RET and
// NOP5/NOP7 over a per-instruction cycle counter, with a 4096x4 internal RAM
// that holds the return-address stack.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rom_addr / rom_data   instruction fetch address (always PC) and word
//   load_en, load_pc/np/sp  preload of PC, NP, SP; restarts at cycle 0
//   pc, np, sp            program counter, new-page register, stack pointer
//   a, b, x, y            data/index registers (held by every instruction)
//   dbg_addr / dbg_data   combinational read of the internal RAM
//   final_fetch, done     high during the last cycle of each instruction
module bench (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    input  logic        load_en,
    input  logic [12:0] load_pc,
    input  logic [4:0]  load_np,
    input  logic [7:0]  load_sp,
    output logic [12:0] pc,
    output logic [4:0]  np,
    output logic [7:0]  sp,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [11:0] x,
    output logic [11:0] y,
    input  logic [11:0] dbg_addr,
    output logic [3:0]  dbg_data,
    output logic        final_fetch,
    output logic        done
);

    localparam int unsigned PC_W   = 13;
    localparam int unsigned SP_W   = 8;
    localparam int unsigned OP_W   = 12;
    localparam int unsigned CYC_W  = 3;
    localparam int unsigned RAM_AW = 12;
    localparam int unsigned RAM_DW = 4;
    localparam int unsigned RAM_D  = 4096;

    localparam logic [CYC_W-1:0] LAST_SHORT = CYC_W'(4);
    localparam logic [CYC_W-1:0] LAST_LONG  = CYC_W'(6);

    typedef enum logic [2:0] {
        K_NOP5,
        K_NOP7,
        K_JP,
        K_CALL,
        K_CALZ,
        K_RET
    } kind_t;

    logic [RAM_DW-1:0] ram [RAM_D];

    logic [CYC_W-1:0]  cyc, cyc_n;
    logic [OP_W-1:0]   op_q, op_cur;
    logic [OP_W-1:0]   pop_q, pop_n;
    logic [PC_W-1:0]   pc_n;
    logic [SP_W-1:0]   sp_n;
    logic              ff_q, ff_n;
    logic [CYC_W-1:0]  last_cyc;
    logic [OP_W-1:0]   ret_addr;
    logic [RAM_DW-1:0] stack_rdata;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_DW-1:0] ram_wdata;
    kind_t             kind;

    // Opcode decode; anything unrecognised behaves as NOP5.
    function automatic kind_t decode(input logic [OP_W-1:0] op);
        kind_t k;
        k = K_NOP5;
        if (op == 12'hFFF)          k = K_NOP7;
        else if (op == 12'hFDF)     k = K_RET;
        else if (op[11:8] == 4'h0)  k = K_JP;
        else if (op[11:8] == 4'h4)  k = K_CALL;
        else if (op[11:8] == 4'h5)  k = K_CALZ;
        return k;
    endfunction

    assign rom_addr    = pc;
    assign final_fetch = ff_q;
    assign done        = ff_q;
    assign dbg_data    = ram[dbg_addr];
    assign stack_rdata = ram[{4'h0, sp}];

    // Cycle 0 decodes straight from the ROM; later cycles use the latched opcode.
    assign op_cur   = (cyc == '0) ? rom_data : op_q;
    assign kind     = decode(op_cur);
    assign last_cyc = (kind == K_NOP7 || kind == K_CALL || kind == K_CALZ || kind == K_RET)
                      ? LAST_LONG : LAST_SHORT;
    // Page-local increment: carry never reaches the bank bit.
    assign ret_addr = pc[11:0] + 12'd1;

    // Next-state and stack-access logic for the current cycle.
    always_comb begin
        pc_n      = pc;
        sp_n      = sp;
        pop_n     = pop_q;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        cyc_n     = (cyc == last_cyc) ? '0 : CYC_W'(cyc + CYC_W'(1));

        case (kind)
            K_CALL, K_CALZ: begin
                if (cyc >= CYC_W'(1) && cyc <= CYC_W'(3)) begin
                    // Pre-decrement push: SP-1, SP-2, SP-3 of the entry SP.
                    ram_we    = 1'b1;
                    ram_waddr = {4'h0, SP_W'(sp - 8'd1)};
                    sp_n      = SP_W'(sp - 8'd1);
                    case (cyc)
                        CYC_W'(1): ram_wdata = ret_addr[11:8];
                        CYC_W'(2): ram_wdata = ret_addr[7:4];
                        default:   ram_wdata = ret_addr[3:0];
                    endcase
                end else if (cyc == CYC_W'(4)) begin
                    pc_n = {pc[12], (kind == K_CALL) ? np[3:0] : 4'h0, op_q[7:0]};
                end
            end
            K_RET: begin
                if (cyc >= CYC_W'(1) && cyc <= CYC_W'(3)) begin
                    sp_n = SP_W'(sp + 8'd1);
                    case (cyc)
                        CYC_W'(1): pop_n[3:0]  = stack_rdata;
                        CYC_W'(2): pop_n[7:4]  = stack_rdata;
                        default:   pop_n[11:8] = stack_rdata;
                    endcase
                end else if (cyc == CYC_W'(4)) begin
                    pc_n = {pc[12], pop_q};
                end
            end
            K_JP: begin
                if (cyc == CYC_W'(2)) pc_n = {pc[12], np[3:0], op_q[7:0]};
            end
            default: begin
                if (cyc == last_cyc) pc_n = {pc[12], ret_addr};
            end
        endcase

        // Every instruction is at least 5 cycles, so cycle 0 is never last.
        ff_n = (cyc_n == last_cyc);
    end

    // Architectural and sequencing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= 13'h0100;
            np    <= 5'h01;
            sp    <= 8'h00;
            cyc   <= '0;
            ff_q  <= 1'b0;
            op_q  <= '0;
            pop_q <= '0;
        end else if (load_en) begin
            pc    <= load_pc;
            np    <= load_np;
            sp    <= load_sp;
            cyc   <= '0;
            ff_q  <= 1'b0;
        end else begin
            pc    <= pc_n;
            sp    <= sp_n;
            cyc   <= cyc_n;
            ff_q  <= ff_n;
            pop_q <= pop_n;
            if (cyc == '0) op_q <= rom_data;
        end
    end

    // Data registers: no implemented instruction modifies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            x <= '0;
            y <= '0;
        end
    end

    // Stack RAM write port; reset and preload abandon the current push.
    always_ff @(posedge clk) begin
        if (ram_we && !reset && !load_en) ram[ram_waddr] <= ram_wdata;
    end

endmodule

// File: tb/tb_bench.sv
module tb_bench;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        load_en;
    logic [12:0] load_pc;
    logic [4:0]  load_np;
    logic [7:0]  load_sp;
    logic [12:0] pc;
    logic [4:0]  np;
    logic [7:0]  sp;
    logic [3:0]  a, b;
    logic [11:0] x, y;
    logic [11:0] dbg_addr;
    logic [3:0]  dbg_data;
    logic        final_fetch;
    logic        done;

    logic [11:0] rom [0:8191];
    int          passed = 0;
    int          total  = 0;
    int          len;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    bench dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .load_en(load_en), .load_pc(load_pc), .load_np(load_np), .load_sp(load_sp),
        .pc(pc), .np(np), .sp(sp), .a(a), .b(b), .x(x), .y(y),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .final_fetch(final_fetch), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [12:0] p, input logic [4:0] n, input logic [7:0] s);
        load_en = 1'b1;
        load_pc = p;
        load_np = n;
        load_sp = s;
        step();
        load_en = 1'b0;
    endtask

    // Steps from cycle 0 until final_fetch; returns instruction length.
    task automatic wait_final(output int l);
        l = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            l++;
            if (final_fetch === 1'b1) break;
        end
        l = l + 1;
    endtask

    task automatic check_ram(input string tag, input logic [11:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic check_regs_zero(input string tag);
        check(tag, {a, b, x[11:0], y[11:0]}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 12'hFFB;
        reset    = 1'b1;
        load_en  = 1'b0;
        load_pc  = '0;
        load_np  = '0;
        load_sp  = '0;
        dbg_addr = '0;
        step();
        step();

        check("rst_pc", 32'(pc), 32'h0100);
        check("rst_np", 32'(np), 32'h01);
        check("rst_sp", 32'(sp), 32'h00);
        check_regs_zero("rst_abxy");
        check("rst_ff", {30'h0, final_fetch, done}, 32'h0);
        reset = 1'b0;

        // CALL 0x4AB from 0x1234, NP=0x12
        rom[13'h1234] = 12'h4AB;
        load(13'h1234, 5'h12, 8'h44);
        wait_final(len);
        check("call_len", 32'(len), 32'd7);
        check("call_pc", 32'(pc), 32'h12AB);
        check("call_romaddr", 32'(rom_addr), 32'h12AB);
        check("call_done", 32'(done), 32'h1);
        check("call_sp", 32'(sp), 32'h41);
        check_ram("call_ram43", 12'h043, 4'h2);
        check_ram("call_ram42", 12'h042, 4'h3);
        check_ram("call_ram41", 12'h041, 4'h5);
        check_regs_zero("call_abxy");
        check("call_np", 32'(np), 32'h12);
        step();
        check("call_next_c0", 32'(final_fetch), 32'h0);

        // CALL ignores NBP
        rom[13'h1234] = 12'h444;
        load(13'h1234, 5'h0A, 8'h44);
        wait_final(len);
        check("callnbp_len", 32'(len), 32'd7);
        check("callnbp_pc", 32'(pc), 32'h1A44);
        check("callnbp_sp", 32'(sp), 32'h41);

        // CALZ 0x569 from 0x1ABC
        rom[13'h1ABC] = 12'h569;
        load(13'h1ABC, 5'h15, 8'h44);
        wait_final(len);
        check("calz_len", 32'(len), 32'd7);
        check("calz_pc", 32'(pc), 32'h1069);
        check("calz_sp", 32'(sp), 32'h41);
        check_ram("calz_ram43", 12'h043, 4'hA);
        check_ram("calz_ram42", 12'h042, 4'hB);
        check_ram("calz_ram41", 12'h041, 4'hD);

        // Return-address carry across page nibbles
        rom[13'h05FF] = 12'h4AB;
        load(13'h05FF, 5'h03, 8'h44);
        wait_final(len);
        check("callc_pc", 32'(pc), 32'h03AB);
        check_ram("callc_ram43", 12'h043, 4'h6);
        check_ram("callc_ram42", 12'h042, 4'h0);
        check_ram("callc_ram41", 12'h041, 4'h0);
        rom[13'h05FF] = 12'h5AB;
        load(13'h05FF, 5'h03, 8'h44);
        wait_final(len);
        check("calzc_pc", 32'(pc), 32'h00AB);

        // CALL then RET at the target
        rom[13'h1234] = 12'h4AB;
        rom[13'h12AB] = 12'hFDF;
        load(13'h1234, 5'h12, 8'h44);
        wait_final(len);
        step();
        wait_final(len);
        check("ret_len", 32'(len), 32'd7);
        check("ret_pc", 32'(pc), 32'h1235);
        check("ret_sp", 32'(sp), 32'h44);

        // Wrap: CALL at 0x0FFF pushes 0,0,0 and RET lands on 0x0000
        rom[13'h0FFF] = 12'h4AB;
        rom[13'h03AB] = 12'hFDF;
        load(13'h0FFF, 5'h03, 8'h44);
        wait_final(len);
        check("wrapcall_pc", 32'(pc), 32'h03AB);
        check_ram("wrap_ram43", 12'h043, 4'h0);
        step();
        wait_final(len);
        check("wrapret_pc", 32'(pc), 32'h0000);
        check("wrapret_sp", 32'(sp), 32'h44);

        // JP 0x0AB with NP=0x07
        rom[13'h0200] = 12'h0AB;
        load(13'h0200, 5'h07, 8'h20);
        wait_final(len);
        check("jp_len", 32'(len), 32'd5);
        check("jp_pc", 32'(pc), 32'h07AB);
        check("jp_sp", 32'(sp), 32'h20);

        // Unimplemented opcode as NOP5; increment stays in bank 1
        rom[13'h1FFF] = 12'h123;
        load(13'h1FFF, 5'h00, 8'h20);
        wait_final(len);
        check("nop5_len", 32'(len), 32'd5);
        step();
        check("nop5_pc", 32'(pc), 32'h1000);

        // NOP7
        rom[13'h0300] = 12'hFFF;
        load(13'h0300, 5'h00, 8'h20);
        wait_final(len);
        check("nop7_len", 32'(len), 32'd7);
        step();
        check("nop7_pc", 32'(pc), 32'h0301);

        // SP wraparound during push
        rom[13'h0ABC] = 12'h4AB;
        load(13'h0ABC, 5'h01, 8'h01);
        wait_final(len);
        check("spw_sp", 32'(sp), 32'hFE);
        check_ram("spw_ram000", 12'h000, 4'hA);
        check_ram("spw_ram0ff", 12'h0FF, 4'hB);
        check_ram("spw_ram0fe", 12'h0FE, 4'hD);

        // Reset during cycle 2 of a CALL
        rom[13'h1234] = 12'h4AB;
        load(13'h1234, 5'h12, 8'h44);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid_pc", 32'(pc), 32'h0100);
        check("rmid_np", 32'(np), 32'h01);
        check("rmid_sp", 32'(sp), 32'h00);
        check("rmid_ff", 32'(final_fetch), 32'h0);
        wait_final(len);
        check("rmid_len", 32'(len), 32'd5);
        step();
        check("rmid_next_pc", 32'(pc), 32'h0101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
